// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one ALU between NUM_REQ requesters, with start/busy/done sequencing.
// Optional watchdog on the WAIT state is compiled in with `define ARB_WATCHDOG_EN.
module alu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  input  logic [4*NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   alu_start,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [3:0]             alu_opcode,
  input  logic                   alu_busy,
  input  logic                   alu_done,
  input  logic [7:0]             alu_result,
  input  logic [3:0]             alu_flags,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_result,
  output logic [3:0]             rsp_flags,
  output logic                   rsp_err
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [IW-1:0] last, win;
  logic any;
  int idx;
  // Scan from farthest to nearest so the requester closest after last wins.
  always_comb begin
    win = last;
    any = 1'b0;
    idx = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (req[idx]) begin
        win = idx[IW-1:0];
        any = 1'b1;
      end
    end
  end
`ifdef ARB_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd;
`else
  assign rsp_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= IW'(NUM_REQ - 1);
      gnt        <= '0;
      rsp_valid  <= '0;
      alu_start  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
`ifdef ARB_WATCHDOG_EN
      rsp_err    <= 1'b0;
      wd         <= '0;
`endif
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE, RESP: begin
          if (any) begin
            alu_a      <= req_a[8*win +: 8];
            alu_b      <= req_b[8*win +: 8];
            alu_opcode <= req_op[4*win +: 4];
            last       <= win;
            gnt        <= NUM_REQ'(1) << win;
            alu_start  <= 1'b1;
            state      <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (!alu_busy && !alu_done) begin
            alu_start <= 1'b0;
            state     <= WAIT;
`ifdef ARB_WATCHDOG_EN
            wd        <= '0;
`endif
          end
        end
        WAIT: begin
          if (alu_done) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_valid  <= NUM_REQ'(1) << last;
            state      <= RESP;
`ifdef ARB_WATCHDOG_EN
            rsp_err    <= 1'b0;
          end else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b1;
            rsp_valid  <= NUM_REQ'(1) << last;
            state      <= RESP;
          end else begin
            wd <= wd + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed vectors plus multi-cycle sequences against a behavioural ALU stand-in.
module tb_alu_req_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [15:0] req_op = '0;
  logic [3:0] gnt, rsp_valid, rsp_flags, alu_opcode, alu_flags;
  logic alu_start, alu_busy, alu_done, rsp_err;
  logic [7:0] alu_a, alu_b, alu_result, rsp_result;
  int tests = 0, fails = 0;

  alu_req_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .gnt(gnt), .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_busy(alu_busy), .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // ALU stand-in: IDLE -> EXEC (alat cycles, frozen while hang) -> DONE -> IDLE, no reset.
  logic [1:0] ast = 2'd0;
  int acnt = 0;
  int alat = 1;
  bit hang = 1'b0;
  logic [7:0] ma = '0, mb = '0, mres = '0;
  logic [3:0] mop = '0, mflg = '0;

  function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [8:0] s;
    logic v;
    if (op == 4'd0) begin
      s = {1'b0, a} + {1'b0, b};
      v = (a[7] == b[7]) && (s[7] != a[7]);
    end else if (op == 4'd1) begin
      s = {1'b0, a} - {1'b0, b};
      v = (a[7] != b[7]) && (s[7] != a[7]);
    end else begin
      s = {1'b0, a & b};
      v = 1'b0;
    end
    return {s[7:0], s[7:0] == 8'd0, s[7], s[8], v};
  endfunction

  always @(posedge clk) begin
    case (ast)
      2'd0: if (alu_start) begin
        ast <= 2'd1; acnt <= alat - 1; ma <= alu_a; mb <= alu_b; mop <= alu_opcode;
      end
      2'd1: if (!hang) begin
        if (acnt == 0) begin
          ast <= 2'd2; {mres, mflg} <= alu_fn(ma, mb, mop);
        end else acnt <= acnt - 1;
      end
      default: ast <= 2'd0;
    endcase
  end
  assign alu_busy = (ast == 2'd1);
  assign alu_done = (ast == 2'd2);
  assign alu_result = mres;
  assign alu_flags = mflg;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_op[4*i +: 4] = op;
  endtask

  // Single request from requester i, checked against the 0/1/4 cycle latency.
  task automatic run_txn(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic [7:0] er, input logic [3:0] ef);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    set_ops(i, a, b, op);
    req = oh;
    tick;
    chk("txn_gnt", gnt, oh);
    chk("txn_start", alu_start, 1);
    chk("txn_alu_a", alu_a, a);
    chk("txn_alu_b", alu_b, b);
    chk("txn_alu_op", alu_opcode, op);
    req = '0;
    tick;
    chk("txn_gnt_pulse", gnt, 0);
    tick;
    tick;
    chk("txn_rsp_valid", rsp_valid, oh);
    chk("txn_rsp_result", rsp_result, er);
    chk("txn_rsp_flags", rsp_flags, ef);
    chk("txn_rsp_err", rsp_err, 0);
    tick;
    chk("txn_rsp_pulse", rsp_valid, 0);
  endtask

  typedef struct {
    int idx;
    logic [7:0] a, b;
    logic [3:0] op;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;
  vec_t vecs[7];
  int rr_exp[5];

  initial begin
    vecs[0] = '{1, 8'h05, 8'h03, 4'd0, 8'h08, 4'b0000};
    vecs[1] = '{0, 8'hFF, 8'h01, 4'd0, 8'h00, 4'b1010};
    vecs[2] = '{2, 8'h7F, 8'h01, 4'd0, 8'h80, 4'b0101};
    vecs[3] = '{3, 8'h10, 8'h20, 4'd1, 8'hF0, 4'b0110};
    vecs[4] = '{1, 8'h80, 8'h01, 4'd1, 8'h7F, 4'b0001};
    vecs[5] = '{2, 8'hF0, 8'h0F, 4'd2, 8'h00, 4'b1000};
    vecs[6] = '{0, 8'h3C, 8'hFF, 4'd2, 8'h3C, 4'b0000};
    rr_exp = '{0, 1, 2, 3, 0};

    do_reset;
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_opcode, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_rsp_err", rsp_err, 0);

    for (int v = 0; v < 7; v++)
      run_txn(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].r, vecs[v].f);

    // Continuous load from all four: grants 0,1,2,3,0 every 4 cycles.
    do_reset;
    for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 1), 8'h10, 4'd0);
    req = 4'hF;
    for (int c = 1; c <= 17; c++) begin
      tick;
      if (c % 4 == 1) chk("rr_gnt", gnt, 4'b0001 << rr_exp[c/4]);
      else if (c % 4 == 0) begin
        chk("rr_rsp_valid", rsp_valid, 4'b0001 << rr_exp[c/4 - 1]);
        chk("rr_rsp_result", rsp_result, 8'h11 + 8'(rr_exp[c/4 - 1]));
      end else chk("rr_quiet", {gnt, rsp_valid}, 0);
    end
    req = '0;
    repeat (5) tick;

    // Reset while in WAIT with a slow ALU: ISSUE must hold start until the ALU drains.
    begin
      bit got;
      int cyc;
      do_reset;
      alat = 3;
      set_ops(0, 8'h05, 8'h03, 4'd0);
      req = 4'b0001;
      tick;
      chk("abort_gnt", gnt, 4'b0001);
      req = '0;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      set_ops(0, 8'h20, 8'h22, 4'd0);
      req = 4'b0001;
      chk("abort_no_rsp3", rsp_valid, 0);
      tick;
      chk("abort_regnt", gnt, 4'b0001);
      chk("abort_start4", alu_start, 1);
      req = '0;
      tick;
      chk("abort_start5", alu_start, 1);
      chk("abort_no_rsp5", rsp_valid, 0);
      tick;
      chk("abort_start6", alu_start, 1);
      chk("abort_alu_a", alu_a, 8'h20);
      tick;
      chk("abort_start7", alu_start, 0);
      got = 1'b0;
      cyc = 7;
      for (int n = 0; n < 20 && !got; n++) begin
        tick;
        cyc++;
        if (rsp_valid != 0) got = 1'b1;
      end
      chk("abort_rsp_seen", got, 1);
      chk("abort_rsp_cycle", cyc, 11);
      chk("abort_rsp_valid", rsp_valid, 4'b0001);
      chk("abort_rsp_result", rsp_result, 8'h42);
      alat = 1;
      repeat (2) tick;
    end

    // Requester 2 withdraws before its turn; only requester 0 is served.
    begin
      bit bad2;
      do_reset;
      set_ops(0, 8'h01, 8'h01, 4'd0);
      set_ops(2, 8'h09, 8'h09, 4'd0);
      req = 4'b0101;
      bad2 = 1'b0;
      for (int c = 1; c <= 12; c++) begin
        tick;
        if (c == 3) req = 4'b0001;
        if (c % 4 == 1) chk("drop_gnt", gnt, 4'b0001);
        if (gnt[2] || rsp_valid[2]) bad2 = 1'b1;
      end
      chk("drop_idx2_quiet", bad2, 0);
      req = '0;
      repeat (5) tick;
    end

`ifdef ARB_WATCHDOG_EN
    begin
      bit early;
      do_reset;
      hang = 1'b1;
      set_ops(0, 8'h01, 8'h02, 4'd0);
      req = 4'b0001;
      tick;
      chk("wd_gnt", gnt, 4'b0001);
      req = '0;
      early = 1'b0;
      for (int c = 2; c <= 16; c++) begin
        tick;
        if (rsp_valid != 0) early = 1'b1;
      end
      chk("wd_no_early_rsp", early, 0);
      tick;
      chk("wd_rsp_valid", rsp_valid, 4'b0001);
      chk("wd_rsp_err", rsp_err, 1);
      chk("wd_rsp_result", rsp_result, 0);
      chk("wd_rsp_flags", rsp_flags, 0);
      hang = 1'b0;
      tick;
      run_txn(1, 8'h05, 8'h03, 4'd0, 8'h08, 4'b0000);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares one alu_fsm_controlled instance between NUM_REQ requesters. Each requester posts an operand/opcode request. The block grants one request, drives the ALU start/busy/done handshake, and returns the registered result and flags to the winning requester. It sits between the requester ports and the ALU core and is the only agent allowed to drive the ALU's start, A, B and opcode inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 15, watchdog limit in cycles spent in WAIT (used only with ARB_WATCHDOG_EN)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester request level; held until that requester's gnt bit
req_a  in  8*NUM_REQ  operand A, slice i belongs to requester i
req_b  in  8*NUM_REQ  operand B, slice i belongs to requester i
req_op  in  4*NUM_REQ  opcode, slice i belongs to requester i
gnt  out  NUM_REQ  one-hot, one-cycle pulse: request accepted, operands captured
alu_start  out  1  to ALU start
alu_a  out  8  to ALU A, held stable from ISSUE until WAIT exits
alu_b  out  8  to ALU B, held stable from ISSUE until WAIT exits
alu_opcode  out  4  to ALU opcode, held stable from ISSUE until WAIT exits
alu_busy  in  1  from ALU busy
alu_done  in  1  from ALU done
alu_result  in  8  from ALU result
alu_flags  in  4  from ALU {Z,N,C,V}
rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: response for requester i
rsp_result  out  8  registered result, valid while rsp_valid != 0
rsp_flags  out  4  registered {Z,N,C,V}
rsp_err  out  1  watchdog error, qualified by rsp_valid; constant 0 without the macro

Behaviour:
- Reset:
  - Applies on the clk edge while rst=1; a mid-operation reset simply aborts the operation.
  - After reset: state IDLE; gnt, rsp_valid, alu_start and rsp_err are 0; alu_a, alu_b, alu_opcode, rsp_result and rsp_flags are 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 wins first.
- State ARB = IDLE or RESP. Winner is the first set req bit, searching upward cyclically from last+1.
  - If any bit is set: capture that requester's req_a, req_b and req_op into the alu_* registers, set last=winner, pulse gnt[winner] in the next cycle, go to ISSUE.
  - Otherwise go to (or stay in) IDLE.
- ISSUE:
  - gnt pulse high in the first ISSUE cycle only; alu_start=1.
  - Go to WAIT when alu_busy=0 and alu_done=0, i.e. the ALU is in IDLE and accepts start this cycle. Otherwise stay in ISSUE with alu_start held.
  - This covers ALU residue after a reset, since the ALU itself has no reset.
- WAIT:
  - alu_start=0.
  - On alu_done=1: register alu_result and alu_flags into rsp_*, set rsp_err=0, go to RESP.
- RESP:
  - rsp_valid[last]=1 for exactly one cycle, then arbitrate as in IDLE.
  - This gives back-to-back operation: one op per 4 cycles under continuous load.
- Latency with the ALU idle:
  - req seen at cycle 0 -> gnt at cycle 1 -> ALU EXEC at cycle 2 -> alu_done at cycle 3 -> rsp_valid at cycle 4.
- Boundary rules:
  - req bits seen during ISSUE or WAIT are ignored; they wait for the next arbitration.
  - Dropping req before gnt withdraws the request with no side effect.
  - A requester that re-asserts req in its rsp_valid cycle competes normally; the round-robin rule places it last.
  - alu_done seen in IDLE or ISSUE is ignored.
  - gnt and rsp_valid are never multi-hot.

Optional Feature:
ARB_WATCHDOG_EN:
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES without alu_done, go to RESP with rsp_result=0, rsp_flags=0, rsp_err=1, then resume arbitration.
- Undefined: no counter; WAIT waits indefinitely and rsp_err is tied to 0.

Test Plan:
- Reset then req=4'b0010, req_a[15:8]=8'h05, req_b[15:8]=8'h03, req_op[7:4]=4'b0000 (ADD) -> gnt=4'b0010 at cycle 1, alu_start at cycle 1, rsp_valid=4'b0010 at cycle 4, rsp_result=8'h08, rsp_flags=4'b0000.
- req=4'b1111 held continuously -> grants in order 0,1,2,3,0, spaced every 4 cycles; each rsp_valid matches the preceding gnt index.
- Requester 0 issues ADD 8'hFF+8'h01 -> rsp_result=8'h00, Z=1, C=1; requester 2 issues ADD 8'h7F+8'h01 -> rsp_result=8'h80, N=1, V=1.
- Assert rst in WAIT, then immediately req=4'b0001 -> no rsp_valid for the aborted op; ISSUE holds alu_start until alu_busy=0 and alu_done=0; new response arrives correctly.
- req=4'b0100 dropped one cycle before it would win while req=4'b0001 is held -> only gnt=4'b0001; no activity on index 2.
- With ARB_WATCHDOG_EN, alu_done forced 0 -> rsp_valid after 15 WAIT cycles with rsp_err=1 and rsp_result=8'h00; the next request is served normally.
